// File: rtl/pattern_detector.sv
`timescale 1ns / 1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | pattern_detector: masked, programmable serial pattern recogniser      |
// | with overlap control and saturating match counter.  Revision 1.0      |
// +----------------------------------------------------------------------+
module pattern_detector #(
  parameter int unsigned      PAT_W    = 3,
  parameter logic [PAT_W-1:0] DEF_PAT  = PAT_W'(1),
  parameter logic [PAT_W-1:0] DEF_MASK = '1,
  parameter int unsigned      CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_data_valid,
  input  logic             i_data,
  input  logic             i_pat_load,
  input  logic [PAT_W-1:0] i_pat_in,
  input  logic [PAT_W-1:0] i_mask_in,
  input  logic             i_overlap,
  input  logic             i_clr_count,
  output logic             o_found,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_count_sat
);

  localparam int unsigned         c_FILL_W    = $clog2(PAT_W + 1);
  localparam logic [c_FILL_W-1:0] c_FILL_MAX  = c_FILL_W'(PAT_W);
  localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX   = '1;

  logic [PAT_W-1:0]    r_hist;
  logic [c_FILL_W-1:0] r_fill;
  logic [PAT_W-1:0]    r_pat;
  logic [PAT_W-1:0]    r_mask;
  logic                r_found;
  logic [CNT_W-1:0]    r_count;
  logic                r_sat;

  logic [PAT_W-1:0] w_new_hist;
  logic             w_full;
  logic             w_cmp_ok;
  logic             w_match;

  // The incoming bit completes the window once PAT_W-1 bits are already held.
  assign w_new_hist = {r_hist[PAT_W-2:0], i_data};
  assign w_full     = (r_fill >= c_FILL_LAST);
  assign w_cmp_ok   = (((w_new_hist ^ r_pat) & r_mask) == '0);
  assign w_match    = i_data_valid & ~i_pat_load & w_full & w_cmp_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist  <= '0;
      r_fill  <= '0;
      r_pat   <= DEF_PAT;
      r_mask  <= DEF_MASK;
      r_found <= 1'b0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_found <= w_match;

      if (i_pat_load) begin
        r_pat  <= i_pat_in;
        r_mask <= i_mask_in;
        r_hist <= '0;
        r_fill <= '0;
      end else if (i_data_valid) begin
        r_hist <= w_new_hist;
        if (w_match && !i_overlap) begin
          r_fill <= '0;
        end else if (r_fill != c_FILL_MAX) begin
          r_fill <= r_fill + c_FILL_W'(1);
        end
      end

      if (i_clr_count) begin
        r_count <= '0;
        r_sat   <= 1'b0;
      end else if (w_match && (r_count != c_CNT_MAX)) begin
        r_count <= r_count + CNT_W'(1);
        if (r_count == (c_CNT_MAX - CNT_W'(1))) begin
          r_sat <= 1'b1;
        end
      end
    end
  end

  assign o_found       = r_found;
  assign o_match_count = r_count;
  assign o_count_sat   = r_sat;

endmodule
`default_nettype wire
